eqz_countdown: RTL
==================

Name: eqz_countdown

Overview:
- Parametrised loadable down-counter with registered zero/non-zero status flags (eqz, neqz).
- Controlled by a start/done handshake FSM.
- Used as the iteration controller in the team's datapath/controller pairs (multiply, divide, shift loops): the controller loads a count, the datapath steps it, and eqz/done end the loop.
- Adds over the single-bit zero flag: configurable width, step size, optional auto-reload, abort, and a completion counter.

Parameters:
- WIDTH, 8, counter and load-value width in bits.
- STEP, 1, decrement amount per enabled cycle. Legal range is 1 to 2^WIDTH-1.
- AUTO_RELOAD, 0, when 1 the block reloads the last loaded value after each completion and runs again.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, load request; sampled only in IDLE.
- abort, input, 1, cancels RUN or DONE and returns to IDLE.
- en, input, 1, decrement enable in RUN.
- load_val, input, WIDTH, initial count, captured on an accepted start.
- count, output, WIDTH, current counter register.
- eqz, output, 1, high when count==0.
- neqz, output, 1, high when count!=0.
- busy, output, 1, high while in RUN.
- done, output, 1, one-cycle completion pulse.
- completions, output, 8, number of DONE entries since reset, saturating at 255.

Behaviour:
- States: IDLE, RUN, DONE, held in a 2-bit state register. The unused encoding recovers to IDLE.
- Reset (async, rst_n low):
  - state=IDLE, count=0, reload register=0, completions=0.
  - eqz=1, neqz=0, busy=0, done=0.
- eqz and neqz are a pure decode of the count register: no added latency, and always complementary.
- busy equals (state==RUN). done equals (state==DONE). All outputs are glitch-free register decodes.
- IDLE:
  - start=1 and abort=0: count<=load_val, reload register<=load_val.
  - If load_val!=0, next state is RUN. If load_val==0, next state is DONE.
  - start with abort=1: ignored, stay in IDLE.
- RUN:
  - abort=1: next state IDLE, count holds its value, no done pulse. abort has priority over en.
  - en=0: count holds.
  - en=1 and count>STEP: count<=count-STEP.
  - en=1 and count<=STEP: count<=0 (saturates, never wraps below zero), next state DONE.
  - start is ignored in RUN.
- DONE (exactly one cycle):
  - completions increments on entry, saturating at 255.
  - Next state: if AUTO_RELOAD=1, abort=0 and reload register!=0, then count<=reload register and go to RUN. Otherwise go to IDLE with count=0.
  - start in DONE is ignored.
  - abort in DONE goes to IDLE; done is still high for that cycle.
- Latency, STEP=1, en held high, load_val=N>0:
  - start accepted at edge 0; busy high in cycles 1..N.
  - count=0 and done=1 in cycle N+1.
  - busy falls in the same cycle done rises.
- General latency: done follows ceil(N/STEP) enabled RUN cycles.
- Reset asserted mid-operation clears everything immediately, regardless of clock. After rst_n deasserts, the block is in IDLE and waits for a new start.
- No combinational path from any input to any output.

Test Plan:
- Reset mid-RUN (count=5): rst_n low asynchronously -> count=0, eqz=1, busy=0, done=0 before the next clk edge; IDLE after release.
- WIDTH=8, STEP=1, start with load_val=4, en=1 -> busy for 4 cycles; count 4,3,2,1; then count=0, eqz=1, done=1 for one cycle; completions=1.
- STEP=3, load_val=7, en=1 -> count 7,4,1, then 0 (saturates, no wrap); done after 3 RUN cycles. Toggle en low for 2 cycles mid-run -> count holds and done is delayed 2 cycles.
- load_val=0 on start -> no busy cycle; done=1 in the next cycle; eqz stays 1. Zero-load is counted in completions.
- Abort at count=2 during RUN -> IDLE next cycle, count=2, neqz=1, no done, completions unchanged. start+abort together in IDLE -> no load.
- AUTO_RELOAD=1, load_val=3, en=1 for 20 cycles -> a done pulse every 4 cycles (3 RUN + 1 DONE) and completions increments by 1 each time. Then abort -> IDLE. Separately, force 300 completions -> completions holds at 255.

Source files
------------

// File: rtl/eqz_countdown_if.sv
// Handshake and status bundle for the eqz_countdown iteration controller.
// The controller side (master) drives start/abort/en/load_val and observes the counter status.
interface eqz_countdown_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             abort;
  logic             en;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             eqz;
  logic             neqz;
  logic             busy;
  logic             done;
  logic [7:0]       completions;

  modport master (
    output start, abort, en, load_val,
    input  count, eqz, neqz, busy, done, completions
  );

  modport slave (
    input  start, abort, en, load_val,
    output count, eqz, neqz, busy, done, completions
  );
endinterface

// File: rtl/eqz_countdown.sv
// Loadable down-counter with zero/non-zero flags, start/done handshake FSM,
// optional auto-reload, abort and a saturating completion counter.
module eqz_countdown #(
  parameter int WIDTH       = 8,
  parameter int STEP        = 1,
  parameter int AUTO_RELOAD = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  eqz_countdown_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  state_t           state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] reload;
  logic [7:0]       completions;
  logic [7:0]       completions_inc;

  assign completions_inc = (completions == 8'hFF) ? completions : completions + 8'd1;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make the update order matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      reload      <= '0;
      completions <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            count  <= bus.load_val;
            reload <= bus.load_val;
            if (bus.load_val != '0) begin
              state <= RUN;
            end else begin
              state       <= DONE;
              completions <= completions_inc;
            end
          end
        end
        RUN: begin
          if (bus.abort) begin
            state <= IDLE;
          end else if (bus.en) begin
            if (count > STEP_W) begin
              count <= count - STEP_W;
            end else begin
              // Saturate at zero instead of wrapping when the last step overshoots.
              count       <= '0;
              state       <= DONE;
              completions <= completions_inc;
            end
          end
        end
        DONE: begin
          if (AUTO_RELOAD != 0 && !bus.abort && reload != '0) begin
            count <= reload;
            state <= RUN;
          end else begin
            count <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status outputs are decodes of registers only; no input reaches them combinationally.
  assign bus.count       = count;
  assign bus.eqz         = (count == '0);
  assign bus.neqz        = (count != '0);
  assign bus.busy        = (state == RUN);
  assign bus.done        = (state == DONE);
  assign bus.completions = completions;

endmodule
